// File: rtl/riscv_pkg.sv
// Shared FPU types: IEEE flags, rounding modes, operand class and
// the iterative divide/sqrt sequencer state.
package riscv_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;
    localparam logic [2:0] FRM_DYN = 3'b111;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
        logic is_subnormal;
    } fp_class_t;

    localparam logic [31:0] CANONICAL_NAN = 32'h7FC00000;
    localparam int          ITER_BITS     = 27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ITER,
        ST_DONE
    } fds_state_e;

endpackage

// File: rtl/fp_classify.sv
// Single-precision operand classifier with leading-zero normalisation
// of the significand (subnormals come out with bit23 set).
module fp_classify
    import riscv_pkg::*;
(
    input  logic [31:0] i_op,
    output fp_class_t   o_class,
    output logic        o_sign,
    output logic [7:0]  o_exp_field,
    output logic [4:0]  o_lzc,
    output logic [23:0] o_mant
);

    logic        w_exp_zero;
    logic        w_exp_ones;
    logic        w_frac_zero;
    logic [23:0] w_sig;
    logic [4:0]  w_lzc;

    assign o_sign      = i_op[31];
    assign o_exp_field = i_op[30:23];
    assign w_exp_zero  = (i_op[30:23] == 8'h00);
    assign w_exp_ones  = (i_op[30:23] == 8'hFF);
    assign w_frac_zero = (i_op[22:0] == 23'd0);
    assign w_sig       = {~w_exp_zero, i_op[22:0]};

    // Highest set bit wins: ascending scan, last hit overwrites.
    always_comb begin
        w_lzc = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (w_sig[i]) begin
                w_lzc = 5'(23 - i);
            end
        end
    end

    assign o_lzc  = w_lzc;
    assign o_mant = w_sig << w_lzc;

    always_comb begin
        o_class              = '0;
        o_class.is_zero      = w_exp_zero && w_frac_zero;
        o_class.is_subnormal = w_exp_zero && !w_frac_zero;
        o_class.is_inf       = w_exp_ones && w_frac_zero;
        o_class.is_nan       = w_exp_ones && !w_frac_zero;
        o_class.is_snan      = w_exp_ones && !w_frac_zero && !i_op[22];
    end

endmodule

// File: rtl/fp_div_sqrt_iter.sv
// Iterative FDIV.S / FSQRT.S, one result bit per cycle, unrounded output.
// FP_SQRT_EN: when defined the root datapath exists; otherwise sqrt -> NaN/nv.
module fp_div_sqrt_iter
    import riscv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_op_sqrt,
    input  logic [31:0] i_operand_a,
    input  logic [31:0] i_operand_b,
    input  logic [2:0]  i_rounding_mode,
    input  logic        i_kill,
    output logic        o_valid,
    input  logic        i_out_ready,
    output logic        o_sign,
    output logic [9:0]  o_exponent,
    output logic [24:0] o_mantissa,
    output logic        o_guard,
    output logic        o_round,
    output logic        o_sticky,
    output logic        o_is_zero,
    output logic [2:0]  o_rounding_mode,
    output logic        o_special,
    output logic [31:0] o_special_result,
    output fp_flags_t   o_flags
);

    fds_state_e  r_state;
    fds_state_e  w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sqrt;
    logic [2:0]  r_rm;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [23:0] r_den;
    logic [30:0] r_rem;
    logic [26:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_special;
    logic [31:0] r_spec_res;
    fp_flags_t   r_spec_flags;
`ifdef FP_SQRT_EN
    logic [53:0] r_rad;
`endif

    fp_class_t   w_ca;
    fp_class_t   w_cb;
    logic        w_sa;
    logic        w_sb;
    logic [7:0]  w_efa;
    logic [7:0]  w_efb;
    logic [4:0]  w_lza;
    logic [4:0]  w_lzb;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [9:0]  w_ea;
    logic [9:0]  w_eb;

    fp_classify u_cls_a (
        .i_op        (r_a),
        .o_class     (w_ca),
        .o_sign      (w_sa),
        .o_exp_field (w_efa),
        .o_lzc       (w_lza),
        .o_mant      (w_ma)
    );

    fp_classify u_cls_b (
        .i_op        (r_b),
        .o_class     (w_cb),
        .o_sign      (w_sb),
        .o_exp_field (w_efb),
        .o_lzc       (w_lzb),
        .o_mant      (w_mb)
    );

    assign w_ea = w_ca.is_subnormal ? 10'd1 - {5'd0, w_lza} : {2'b00, w_efa};
    assign w_eb = w_cb.is_subnormal ? 10'd1 - {5'd0, w_lzb} : {2'b00, w_efb};

    logic        w_dsign;
    logic        w_spec;
    logic [31:0] w_spec_res;
    fp_flags_t   w_spec_flags;

    assign w_dsign = w_sa ^ w_sb;

    always_comb begin
        w_spec       = 1'b0;
        w_spec_res   = 32'd0;
        w_spec_flags = '0;
        if (r_sqrt) begin
`ifdef FP_SQRT_EN
            if (w_ca.is_nan) begin
                w_spec          = 1'b1;
                w_spec_res      = CANONICAL_NAN;
                w_spec_flags.nv = w_ca.is_snan;
            end else if (w_sa && !w_ca.is_zero) begin
                w_spec          = 1'b1;
                w_spec_res      = CANONICAL_NAN;
                w_spec_flags.nv = 1'b1;
            end else if (w_ca.is_zero) begin
                w_spec     = 1'b1;
                w_spec_res = {w_sa, 31'd0};
            end else if (w_ca.is_inf) begin
                w_spec     = 1'b1;
                w_spec_res = {1'b0, 8'hFF, 23'd0};
            end
`else
            w_spec          = 1'b1;
            w_spec_res      = CANONICAL_NAN;
            w_spec_flags.nv = 1'b1;
`endif
        end else begin
            if (w_ca.is_nan || w_cb.is_nan) begin
                w_spec          = 1'b1;
                w_spec_res      = CANONICAL_NAN;
                w_spec_flags.nv = w_ca.is_snan || w_cb.is_snan;
            end else if ((w_ca.is_zero && w_cb.is_zero) ||
                         (w_ca.is_inf && w_cb.is_inf)) begin
                w_spec          = 1'b1;
                w_spec_res      = CANONICAL_NAN;
                w_spec_flags.nv = 1'b1;
            end else if (w_ca.is_inf) begin
                w_spec     = 1'b1;
                w_spec_res = {w_dsign, 8'hFF, 23'd0};
            end else if (w_cb.is_zero) begin
                w_spec          = 1'b1;
                w_spec_res      = {w_dsign, 8'hFF, 23'd0};
                w_spec_flags.dz = 1'b1;
            end else if (w_cb.is_inf || w_ca.is_zero) begin
                w_spec     = 1'b1;
                w_spec_res = {w_dsign, 31'd0};
            end
        end
    end

    // Pre-shift the dividend so the first quotient bit is always 1.
    logic        w_dlt;
    logic [9:0]  w_dexp;
    logic [24:0] w_dvd;

    assign w_dlt  = (w_ma < w_mb);
    assign w_dexp = w_ea - w_eb + 10'd127 - {9'd0, w_dlt};
    assign w_dvd  = w_dlt ? {w_ma, 1'b0} : {1'b0, w_ma};

    logic        w_dge;
    logic [30:0] w_drem;

    assign w_dge  = (r_rem >= {7'd0, r_den});
    assign w_drem = w_dge ? r_rem - {7'd0, r_den} : r_rem;

`ifdef FP_SQRT_EN
    // Odd unbiased exponent folds one factor of 2 into the radicand.
    logic [9:0]  w_eu;
    logic [9:0]  w_sexp;
    logic [24:0] w_rad;
    logic [30:0] w_srem;
    logic [30:0] w_trial;
    logic [30:0] w_snext;
    logic        w_sge;

    assign w_eu    = w_ea - 10'd127;
    assign w_sexp  = {w_eu[9], w_eu[9:1]} + 10'd127;
    assign w_rad   = w_eu[0] ? {w_ma, 1'b0} : {1'b0, w_ma};
    assign w_srem  = {r_rem[28:0], r_rad[53:52]};
    assign w_trial = {2'b00, r_q, 2'b01};
    assign w_sge   = (w_srem >= w_trial);
    assign w_snext = w_sge ? w_srem - w_trial : w_srem;
`endif

    logic        w_qbit;
    logic [30:0] w_rem_next;

    always_comb begin
        w_qbit     = w_dge;
        w_rem_next = w_drem << 1;
`ifdef FP_SQRT_EN
        if (r_sqrt) begin
            w_qbit     = w_sge;
            w_rem_next = w_snext;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_kill) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_valid) w_next = ST_NORM;
                ST_NORM: w_next = w_spec ? ST_DONE : ST_ITER;
                ST_ITER: begin
                    if (r_cnt == 5'(ITER_BITS - 1)) begin
                        w_next = ST_DONE;
                    end
                end
                ST_DONE: if (i_out_ready) w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sqrt       <= 1'b0;
            r_rm         <= '0;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_den        <= '0;
            r_rem        <= '0;
            r_q          <= '0;
            r_cnt        <= '0;
            r_special    <= 1'b0;
            r_spec_res   <= '0;
            r_spec_flags <= '0;
`ifdef FP_SQRT_EN
            r_rad        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_a    <= i_operand_a;
                        r_b    <= i_operand_b;
                        r_sqrt <= i_op_sqrt;
                        r_rm   <= i_rounding_mode;
                    end
                end
                ST_NORM: begin
                    r_special    <= w_spec;
                    r_spec_res   <= w_spec_res;
                    r_spec_flags <= w_spec_flags;
                    r_q          <= '0;
                    r_cnt        <= '0;
                    r_sign       <= w_dsign;
                    r_exp        <= w_dexp;
                    r_den        <= w_mb;
                    r_rem        <= {6'd0, w_dvd};
`ifdef FP_SQRT_EN
                    if (r_sqrt) begin
                        r_sign <= 1'b0;
                        r_exp  <= w_sexp;
                        r_rem  <= '0;
                        r_rad  <= {w_rad, 29'd0};
                    end
`endif
                end
                ST_ITER: begin
                    r_q   <= {r_q[25:0], w_qbit};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 5'd1;
`ifdef FP_SQRT_EN
                    r_rad <= r_rad << 2;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    logic w_done;
    logic w_norm_out;
    logic w_spec_out;

    assign w_done     = (r_state == ST_DONE);
    assign w_norm_out = w_done && !r_special;
    assign w_spec_out = w_done && r_special;

    always_comb begin
        o_ready          = (r_state == ST_IDLE);
        o_valid          = w_done && !i_kill;
        o_sign           = 1'b0;
        o_exponent       = '0;
        o_mantissa       = '0;
        o_guard          = 1'b0;
        o_round          = 1'b0;
        o_sticky         = 1'b0;
        o_is_zero        = 1'b0;
        o_rounding_mode  = '0;
        o_special        = 1'b0;
        o_special_result = '0;
        o_flags          = '0;
        if (w_done) begin
            o_rounding_mode = r_rm;
        end
        if (w_norm_out) begin
            o_sign     = r_sign;
            o_exponent = r_exp;
            o_mantissa = r_q[26:2];
            o_guard    = r_q[1];
            o_round    = r_q[0];
            o_sticky   = (r_rem != 31'd0);
        end
        if (w_spec_out) begin
            o_sign           = r_spec_res[31];
            o_is_zero        = (r_spec_res[30:0] == 31'd0);
            o_special        = 1'b1;
            o_special_result = r_spec_res;
            o_flags          = r_spec_flags;
        end
    end

endmodule

// File: tb/tb_fp_div_sqrt_iter.sv
// Directed self-checking bench for fp_div_sqrt_iter.
module tb_fp_div_sqrt_iter;
    import riscv_pkg::*;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_op_sqrt;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic [2:0]  i_rounding_mode;
    logic        i_kill;
    logic        o_valid;
    logic        i_out_ready;
    logic        o_sign;
    logic [9:0]  o_exponent;
    logic [24:0] o_mantissa;
    logic        o_guard;
    logic        o_round;
    logic        o_sticky;
    logic        o_is_zero;
    logic [2:0]  o_rounding_mode;
    logic        o_special;
    logic [31:0] o_special_result;
    fp_flags_t   o_flags;
    logic [80:0] all_out;

    int checks;
    int failures;

    fp_div_sqrt_iter dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_op_sqrt        (i_op_sqrt),
        .i_operand_a      (i_operand_a),
        .i_operand_b      (i_operand_b),
        .i_rounding_mode  (i_rounding_mode),
        .i_kill           (i_kill),
        .o_valid          (o_valid),
        .i_out_ready      (i_out_ready),
        .o_sign           (o_sign),
        .o_exponent       (o_exponent),
        .o_mantissa       (o_mantissa),
        .o_guard          (o_guard),
        .o_round          (o_round),
        .o_sticky         (o_sticky),
        .o_is_zero        (o_is_zero),
        .o_rounding_mode  (o_rounding_mode),
        .o_special        (o_special),
        .o_special_result (o_special_result),
        .o_flags          (o_flags)
    );

    assign all_out = {o_sign, o_exponent, o_mantissa, o_guard, o_round,
                      o_sticky, o_is_zero, o_rounding_mode, o_special,
                      o_special_result, o_flags};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic sq, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] rm);
        @(negedge clk);
        i_valid         = 1'b1;
        i_op_sqrt       = sq;
        i_operand_a     = a;
        i_operand_b     = b;
        i_rounding_mode = rm;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Accept edge counts as 1; returns the edge after which o_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_hs: got %b want 10", {o_ready, o_valid});
        end
        checks++;
        if (all_out !== 81'd0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", all_out);
        end
        i_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_div();
        int lat;
        start_op(1'b0, 32'h40C00000, 32'h40000000, 3'b000);
        wait_valid(lat);
        checks++;
        if (lat !== 29) begin
            failures++;
            $display("FAIL div6_2 latency: got %0d want 29", lat);
        end
        checks++;
        if ({o_special, o_sign, o_exponent} !== {1'b0, 1'b0, 10'd128}) begin
            failures++;
            $display("FAIL div6_2 sp/sign/exp: got %b %b %0d want 0 0 128",
                     o_special, o_sign, o_exponent);
        end
        checks++;
        if ({o_mantissa, o_guard, o_round, o_sticky} !== {25'h1800000, 3'b000}) begin
            failures++;
            $display("FAIL div6_2 mant/grs: got %h %b%b%b want 1800000 000",
                     o_mantissa, o_guard, o_round, o_sticky);
        end
        checks++;
        if ({o_is_zero, o_rounding_mode} !== 4'b0000) begin
            failures++;
            $display("FAIL div6_2 zero/rm: got %b %b want 0 000", o_is_zero, o_rounding_mode);
        end
        pop();

        start_op(1'b0, 32'h3F800000, 32'h40400000, 3'b001);
        wait_valid(lat);
        checks++;
        if ({o_valid, o_sign, o_exponent} !== {1'b1, 1'b0, 10'd125}) begin
            failures++;
            $display("FAIL div1_3 valid/sign/exp: got %b %b %0d want 1 0 125",
                     o_valid, o_sign, o_exponent);
        end
        checks++;
        if ({o_mantissa, o_guard, o_round, o_sticky} !== {25'h1555555, 3'b011}) begin
            failures++;
            $display("FAIL div1_3 mant/grs: got %h %b%b%b want 1555555 011",
                     o_mantissa, o_guard, o_round, o_sticky);
        end
        checks++;
        if (o_rounding_mode !== 3'b001) begin
            failures++;
            $display("FAIL div1_3 rm: got %b want 001", o_rounding_mode);
        end
        pop();

        start_op(1'b0, 32'hC0C00000, 32'h40000000, 3'b000);
        wait_valid(lat);
        checks++;
        if ({o_sign, o_exponent, o_mantissa} !== {1'b1, 10'd128, 25'h1800000}) begin
            failures++;
            $display("FAIL divneg: got %b %0d %h want 1 128 1800000",
                     o_sign, o_exponent, o_mantissa);
        end
        pop();
    endtask

    task automatic test_sqrt();
        int lat;
`ifdef FP_SQRT_EN
        start_op(1'b1, 32'h40800000, 32'h0, 3'b000);
        wait_valid(lat);
        checks++;
        if (lat !== 29) begin
            failures++;
            $display("FAIL sqrt4 latency: got %0d want 29", lat);
        end
        checks++;
        if ({o_special, o_sign, o_exponent, o_mantissa, o_guard, o_round, o_sticky}
            !== {1'b0, 1'b0, 10'd128, 25'h1000000, 3'b000}) begin
            failures++;
            $display("FAIL sqrt4: got sp%b s%b e%0d m%h grs%b%b%b want 0 0 128 1000000 000",
                     o_special, o_sign, o_exponent, o_mantissa, o_guard, o_round, o_sticky);
        end
        pop();
        start_op(1'b1, 32'h40000000, 32'h0, 3'b000);
        wait_valid(lat);
        checks++;
        if ({o_exponent, o_mantissa, o_guard, o_round, o_sticky}
            !== {10'd127, 25'h16A09E6, 3'b011}) begin
            failures++;
            $display("FAIL sqrt2: got e%0d m%h grs%b%b%b want 127 16a09e6 011",
                     o_exponent, o_mantissa, o_guard, o_round, o_sticky);
        end
        pop();
`else
        start_op(1'b1, 32'h40800000, 32'h0, 3'b000);
        wait_valid(lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL nosqrt latency: got %0d want 2", lat);
        end
        checks++;
        if ({o_special, o_special_result, o_flags} !== {1'b1, 32'h7FC00000, 5'b10000}) begin
            failures++;
            $display("FAIL nosqrt result: got %b %h %b want 1 7fc00000 10000",
                     o_special, o_special_result, o_flags);
        end
        pop();
`endif
    endtask

    task automatic test_special();
        logic        sq  [7];
        logic [31:0] va  [7];
        logic [31:0] vb  [7];
        logic [31:0] res [7];
        logic [4:0]  flg [7];
        logic [31:0] r;
        int lat;
        sq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        va  = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7F800001,
                32'h7FC00000, 32'hBF800000, 32'h7F800000};
        vb  = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000,
                32'h3F800000, 32'h7F800000, 32'h7F800000};
        res = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                32'h7FC00000, 32'h80000000, 32'h7FC00000};
        flg = '{5'b01000, 5'b10000, 5'b10000, 5'b10000,
                5'b00000, 5'b00000, 5'b10000};
        for (int i = 0; i < 7; i++) begin
            start_op(sq[i], va[i], vb[i], 3'b000);
            wait_valid(lat);
            r = res[i];
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL special%0d latency: got %0d want 2", i, lat);
            end
            checks++;
            if ({o_special, o_special_result, o_flags, o_sign} !== {1'b1, r, flg[i], r[31]}) begin
                failures++;
                $display("FAIL special%0d: got sp%b %h fl%b s%b want 1 %h %b %b",
                         i, o_special, o_special_result, o_flags, o_sign, r, flg[i], r[31]);
            end
            checks++;
            if (o_is_zero !== (r[30:0] == 31'd0)) begin
                failures++;
                $display("FAIL special%0d is_zero: got %b", i, o_is_zero);
            end
            pop();
        end
    endtask

    task automatic test_subnormal();
        int lat;
        start_op(1'b0, 32'h00000001, 32'h3F800000, 3'b000);
        wait_valid(lat);
        checks++;
        if (lat !== 29) begin
            failures++;
            $display("FAIL subn latency: got %0d want 29", lat);
        end
        checks++;
        if ({o_exponent, o_mantissa, o_guard, o_round, o_sticky}
            !== {10'h3EA, 25'h1000000, 3'b000}) begin
            failures++;
            $display("FAIL subn: got e%h m%h grs%b%b%b want 3ea 1000000 000",
                     o_exponent, o_mantissa, o_guard, o_round, o_sticky);
        end
        pop();
    endtask

    task automatic test_kill();
        int  lat;
        logic seen;
        seen = 1'b0;
        start_op(1'b0, 32'h40C00000, 32'h40000000, 3'b000);
        repeat (11) begin
            @(posedge clk);
            #1;
            seen = seen | o_valid;
        end
        i_kill = 1'b1;
        @(posedge clk);
        #1;
        i_kill = 1'b0;
        checks++;
        if ({o_ready, o_valid, seen} !== 3'b100) begin
            failures++;
            $display("FAIL kill: got rdy%b vld%b seen%b want 1 0 0", o_ready, o_valid, seen);
        end
        repeat (30) begin
            @(posedge clk);
            #1;
            seen = seen | o_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL kill_noresult: got %b want 0", seen);
        end
        start_op(1'b0, 32'h40C00000, 32'h40000000, 3'b000);
        wait_valid(lat);
        checks++;
        if ({lat[5:0], o_exponent, o_mantissa} !== {6'd29, 10'd128, 25'h1800000}) begin
            failures++;
            $display("FAIL kill_recover: got lat%0d e%0d m%h want 29 128 1800000",
                     lat, o_exponent, o_mantissa);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(1'b0, 32'h40C00000, 32'h40000000, 3'b000);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({o_valid, o_ready, o_exponent, o_mantissa}
                !== {1'b1, 1'b0, 10'd128, 25'h1800000}) begin
                failures++;
                $display("FAIL hold%0d: got v%b r%b e%0d m%h want 1 0 128 1800000",
                         c, o_valid, o_ready, o_exponent, o_mantissa);
            end
            @(posedge clk);
            #1;
        end
        pop();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release: got v%b r%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        start_op(1'b0, 32'h40C00000, 32'h40000000, 3'b010);
        repeat (10) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_ready, o_valid, all_out} !== {2'b10, 81'd0}) begin
            failures++;
            $display("FAIL reset_mid: got r%b v%b %h want 1 0 0", o_ready, o_valid, all_out);
        end
        i_rst = 1'b0;
        repeat (35) begin
            @(posedge clk);
            #1;
            seen = seen | o_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_noresult: got %b want 0", seen);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        i_rst           = 1'b1;
        i_valid         = 1'b0;
        i_op_sqrt       = 1'b0;
        i_operand_a     = '0;
        i_operand_b     = '0;
        i_rounding_mode = '0;
        i_kill          = 1'b0;
        i_out_ready     = 1'b0;
        test_reset();
        test_div();
        test_sqrt();
        test_special();
        test_subnormal();
        test_kill();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_div_sqrt_iter.md
Name: fp_div_sqrt_iter

Overview:
Iterative single-precision FDIV.S/FSQRT.S core in the FPU execute path. It sits directly upstream of the rounding stage and retires one quotient/root bit per cycle. It emits the unrounded sign, a signed biased exponent, a 1.24 mantissa, guard/round/sticky and a zero indication in the exact format the rounder consumes. IEEE special cases (NaN, inf, zero, divide-by-zero) are resolved here and bypass rounding via a special-result path.

Parameters:
ITER_BITS, 27, quotient/root bits generated: 25 mantissa bits plus guard plus round.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  operation request
o_ready  out  1  block idle, can accept request
i_op_sqrt  in  1  0 = divide a/b, 1 = sqrt a (b ignored)
i_operand_a  in  32  IEEE single dividend/radicand
i_operand_b  in  32  IEEE single divisor
i_rounding_mode  in  3  captured and forwarded unchanged
i_kill  in  1  flush: abort in-flight op
o_valid  out  1  result available
i_out_ready  in  1  downstream accepts result
o_sign  out  1  result sign
o_exponent  out  10  signed biased exponent (may be <=0 or >=255)
o_mantissa  out  25  1.24 mantissa, bit24 = integer bit
o_guard, o_round, o_sticky  out  1 each  rounding bits
o_is_zero  out  1  exact zero result
o_rounding_mode  out  3  captured mode
o_special  out  1  o_special_result is final, skip rounding
o_special_result  out  32  final encoding for special cases
o_flags  out  riscv_pkg::fp_flags_t  nv/dz for special cases, else 0

Behaviour:
- Clock i_clk and reset i_rst: reset is synchronous and active-high. In reset: FSM=IDLE; o_ready=1; o_valid=0; all data outputs and o_flags=0.
- FSM states are IDLE, NORM, ITER, DONE.
- IDLE: when i_valid && o_ready, capture operands, op and mode, then go to NORM. o_ready=1 only in IDLE.
- NORM (1 cycle):
  - Classify both operands.
  - Normalise subnormals with a leading-zero count; effective exponent = 1 - lzc.
  - Divide: exp = ea - eb + 127. If ma < mb, the dividend shifts left 1 and exp decrements. This guarantees quotient bit24=1.
  - Sqrt: unbiased e = ea - 127. If e is odd, the radicand shifts left 1. exp = floor(e/2) + 127.
  - Special case detected: load o_special_result/o_flags and go to DONE. Otherwise clear counter and partial remainder, then go to ITER.
- ITER: restoring radix-2 (non-restoring acceptable if bit-exact). One result bit per cycle, MSB first, for ITER_BITS=27 cycles. Counter runs 0..26; on 26 go to DONE.
- DONE:
  - o_valid=1.
  - mantissa = bits[26:2]; guard = bit1; round = bit0; sticky = (remainder != 0).
  - Outputs hold stable while o_valid && !i_out_ready.
  - On i_out_ready, return to IDLE (o_ready=1 the next cycle).
- Latency from accept: normal op, o_valid in cycle 29; special op, cycle 2. No accept is possible in the cycle o_valid drops.
- Special cases (o_special=1, o_sign per IEEE):
  - Any NaN input → 0x7FC00000; nv set if any input is sNaN.
  - 0/0 or inf/inf → 0x7FC00000, nv.
  - x/0 with x finite nonzero → ±inf, dz.
  - inf/x → ±inf; x/inf → ±0; 0/x → ±0.
  - sqrt(-x), x nonzero and not NaN → 0x7FC00000, nv.
  - sqrt(±0) → ±0; sqrt(+inf) → +inf.
- o_is_zero=0 for all non-special results.
- i_kill has priority over everything: next state IDLE, o_valid=0, no result emitted. It applies in any state, including DONE and the accept cycle.
- Divide sign = sa^sb; sqrt sign = 0 for non-special results.

Optional Feature:
- Macro FP_SQRT_EN.
- Defined: sqrt datapath is present, as described above.
- Undefined: no root datapath. A sqrt request is accepted and goes NORM→DONE with o_special=1, o_special_result=0x7FC00000 and nv set (latency 2).

Decomposition:
- riscv_pkg supplies fp_flags_t and the FRM_* constants.
- Add to riscv_pkg: an fp_class_t struct {is_zero, is_inf, is_nan, is_snan, is_subnormal}, a CANONICAL_NAN constant 32'h7FC00000, and a state enum.
- One sub-module, fp_classify: combinational classify plus leading-zero normalise, instantiated once per operand.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000), RNE: o_valid in cycle 29; sign0, exp 128, mantissa 0x1800000, g/r/s=0, o_special=0.
- 1.0/3.0: exp 125, mantissa 0x1555555, guard0, round1, sticky1.
- sqrt(4.0) (0x40800000): exp 128, mantissa 0x1000000, g/r/s=0. sqrt(2.0): exp 127, mantissa 0x16A09E6.
- Special cases:
  - 1.0/0.0 → o_special, 0x7F800000, dz, latency 2.
  - 0/0 → 0x7FC00000, nv.
  - sqrt(-1.0) → 0x7FC00000, nv.
- Smallest subnormal 0x00000001 / 1.0: exp -22, mantissa 0x1000000.
- Assert i_kill in iteration cycle 10: no o_valid; o_ready=1 the next cycle. A new 6.0/2.0 then completes correctly.
- Hold i_out_ready=0 for 5 cycles in DONE: outputs stable. o_ready stays 0 until the handshake completes.
- Assert i_rst mid-ITER: all outputs return to reset values the next cycle.
